// File: rtl/decode_uop_queue_pkg.sv
// Shared uop layout, class/type codes and ARM field constants
// for the decode uop queue and its cracker.
package decode_uop_queue_pkg;

    localparam int UOP_BITS = 64;

    typedef enum logic [1:0] {
        CLS_INTEGER   = 2'd0,
        CLS_INTEGER_M = 2'd1,
        CLS_LOAD      = 2'd2,
        CLS_STORE     = 2'd3
    } uop_class_e;

    typedef enum logic [2:0] {
        TY_IMM       = 3'd0,
        TY_REG       = 3'd1,
        TY_SHIFT_LSL = 3'd2,
        TY_SHIFT_LSR = 3'd3,
        TY_SHIFT_ASR = 3'd4,
        TY_SHIFT_ROR = 3'd5,
        TY_MUL       = 3'd6
    } uop_type_e;

    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] SHIFT_LSL = 2'd0;
    localparam logic [1:0] SHIFT_LSR = 2'd1;
    localparam logic [1:0] SHIFT_ASR = 2'd2;
    localparam logic [1:0] SHIFT_ROR = 2'd3;

    localparam logic [27:0] NOP_HINT = 28'h320F000;

    // Bit 0 is VALID_B; upper bits are reserved and always zero.
    typedef struct packed {
        logic [16:0] rsvd;
        logic        dst0_vld;
        logic [5:0]  dst0;
        logic [5:0]  src2;
        logic [5:0]  src1;
        logic [5:0]  src0;
        logic [11:0] imm12;
        uop_type_e   typ;
        uop_class_e  cls;
        logic [3:0]  cond;
        logic        valid;
    } uop_t;

    function automatic uop_type_e shift_type(input logic [1:0] sh);
        uop_type_e t;
        unique case (sh)
            SHIFT_LSL: t = TY_SHIFT_LSL;
            SHIFT_LSR: t = TY_SHIFT_LSR;
            SHIFT_ASR: t = TY_SHIFT_ASR;
            default:   t = TY_SHIFT_ROR;
        endcase
        return t;
    endfunction

    // TST/TEQ/CMP/CMN only set flags.
    function automatic logic op_writes_rd(input logic [3:0] op);
        return op[3:2] != 2'b10;
    endfunction

endpackage

// File: rtl/decode_uop_queue_uop_cracker.sv
// Combinational ARM decoder: one instruction word to zero,
// one or two uops plus an undefined-encoding flag.
module uop_cracker
    import decode_uop_queue_pkg::*;
#(
    parameter bit         SPLIT_RSR = 1'b1,
    parameter logic [5:0] TMP_REG   = 6'd16
) (
    input  logic [31:0] instr_i,
    output logic [1:0]  n_uops_o,
    output uop_t        uop0_o,
    output uop_t        uop1_o,
    output logic        undef_o
);

    logic [3:0] cond;
    logic [3:0] op;
    logic [5:0] rn, rd, rs, rm;
    logic       wr_rd, is_nv, misc, grp0;
    logic       is_nop, dp_imm, dp_reg, dp_rsr, is_mul, is_ls;
    uop_type_e  sh_ty;
    uop_t       base;

    assign cond  = instr_i[31:28];
    assign op    = instr_i[24:21];
    assign rn    = {2'b00, instr_i[19:16]};
    assign rd    = {2'b00, instr_i[15:12]};
    assign rs    = {2'b00, instr_i[11:8]};
    assign rm    = {2'b00, instr_i[3:0]};
    assign wr_rd = op_writes_rd(op);
    assign sh_ty = shift_type(instr_i[6:5]);

    // Compare ops with S=0 hold MSR, hints, MOVW/MOVT and misc.
    assign misc   = instr_i[24:23] == 2'b10 && !instr_i[20];
    assign is_nv  = cond == COND_NV;
    assign grp0   = !is_nv && instr_i[27:25] == 3'b000;
    assign is_nop = !is_nv && instr_i[27:0] == NOP_HINT;
    assign dp_imm = !is_nv && instr_i[27:25] == 3'b001 && !misc;
    assign dp_reg = grp0 && !misc && !instr_i[4];
    assign dp_rsr = grp0 && !misc && instr_i[4] && !instr_i[7];
    assign is_mul = grp0 && !instr_i[24] && instr_i[7:4] == 4'b1001;
    assign is_ls  = !is_nv && instr_i[27:26] == 2'b01
                    && !(instr_i[25] && instr_i[4]);

    always_comb begin
        base       = '0;
        base.valid = 1'b1;
        base.cond  = cond;
    end

    always_comb begin
        n_uops_o = 2'd0;
        undef_o  = 1'b0;
        uop0_o   = base;
        uop1_o   = base;
        unique case (1'b1)
            is_nop: ;
            dp_imm: begin
                n_uops_o        = 2'd1;
                uop0_o.cls      = CLS_INTEGER;
                uop0_o.typ      = TY_IMM;
                uop0_o.imm12    = instr_i[11:0];
                uop0_o.src0     = rn;
                uop0_o.dst0     = rd;
                uop0_o.dst0_vld = wr_rd;
            end
            dp_reg: begin
                n_uops_o        = 2'd1;
                uop0_o.src0     = rn;
                uop0_o.src1     = rm;
                uop0_o.dst0     = rd;
                uop0_o.dst0_vld = wr_rd;
                if (instr_i[11:5] == 7'd0) begin
                    uop0_o.cls = CLS_INTEGER;
                    uop0_o.typ = TY_REG;
                end else begin
                    uop0_o.cls   = CLS_INTEGER_M;
                    uop0_o.typ   = sh_ty;
                    uop0_o.imm12 = instr_i[11:0];
                end
            end
            dp_rsr: begin
                if (SPLIT_RSR && cond == COND_AL) begin
                    n_uops_o        = 2'd2;
                    uop0_o.cls      = CLS_INTEGER;
                    uop0_o.typ      = sh_ty;
                    uop0_o.src0     = rm;
                    uop0_o.src1     = rs;
                    uop0_o.dst0     = TMP_REG;
                    uop0_o.dst0_vld = 1'b1;
                    uop1_o.cls      = CLS_INTEGER;
                    uop1_o.typ      = TY_REG;
                    uop1_o.src0     = rn;
                    uop1_o.src1     = TMP_REG;
                    uop1_o.dst0     = rd;
                    uop1_o.dst0_vld = wr_rd;
                end else begin
                    n_uops_o        = 2'd1;
                    uop0_o.cls      = (cond != COND_AL) ? CLS_INTEGER
                                                        : CLS_INTEGER_M;
                    uop0_o.typ      = sh_ty;
                    uop0_o.src0     = rn;
                    uop0_o.src1     = rm;
                    uop0_o.src2     = rs;
                    uop0_o.dst0     = rd;
                    uop0_o.dst0_vld = wr_rd;
                end
            end
            is_mul: begin
                n_uops_o        = 2'd1;
                uop0_o.cls      = CLS_INTEGER_M;
                uop0_o.typ      = TY_MUL;
                uop0_o.src0     = rm;
                uop0_o.src1     = rs;
                uop0_o.src2     = rd;
                uop0_o.dst0     = rn;
                uop0_o.dst0_vld = 1'b1;
            end
            is_ls: begin
                n_uops_o     = 2'd1;
                uop0_o.cls   = instr_i[20] ? CLS_LOAD : CLS_STORE;
                uop0_o.src0  = rn;
                uop0_o.imm12 = instr_i[11:0];
                if (instr_i[20]) begin
                    uop0_o.dst0     = rd;
                    uop0_o.dst0_vld = 1'b1;
                end else begin
                    uop0_o.src1 = rd;
                end
            end
            default: undef_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_uop_queue.sv
// Decode stage: cracks instructions into uops and buffers them
// in a DEPTH-entry FIFO with valid/ready on both sides.
module decode_uop_queue
    import decode_uop_queue_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter int         UOP_W     = 64,
    parameter bit         SPLIT_RSR = 1'b1,
    parameter logic [5:0] TMP_REG   = 6'd16,
    localparam int        PW        = $clog2(DEPTH),
    localparam int        CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid_i,
    input  logic [31:0]      instr_i,
    output logic             instr_ready_o,
    input  logic             flush_i,
    output logic             uop_valid_o,
    output logic [UOP_W-1:0] uop_o,
    input  logic             uop_ready_i,
    output logic [CW-1:0]    count_o,
    output logic             undef_o
);

    if (UOP_W != UOP_BITS) begin : g_bad_uop_w
        $error("UOP_W must equal the package uop width");
    end

    uop_t          mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, wr_p1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          undef_q;
    logic [1:0]    crk_n, push_n;
    uop_t          crk_u0, crk_u1, head;
    logic          crk_undef, accept, pop;

    uop_cracker #(
        .SPLIT_RSR (SPLIT_RSR),
        .TMP_REG   (TMP_REG)
    ) u_cracker (
        .instr_i  (instr_i),
        .n_uops_o (crk_n),
        .uop0_o   (crk_u0),
        .uop1_o   (crk_u1),
        .undef_o  (crk_undef)
    );

    // Two free slots are always reserved so a crack never overflows.
    assign instr_ready_o = rst && !flush_i
                           && cnt_q <= CW'(DEPTH - 2);
    assign accept = instr_valid_i && instr_ready_o;
    assign pop    = uop_valid_o && uop_ready_i;
    assign push_n = accept ? crk_n : 2'd0;
    assign wr_p1  = wr_q + PW'(1);

    assign uop_valid_o = cnt_q != '0;
    assign head        = uop_valid_o ? mem_q[rd_q] : '0;
    assign uop_o       = head;
    assign count_o     = cnt_q;
    assign undef_o     = undef_q;

    always_comb begin
        wr_d  = wr_q + PW'(push_n);
        rd_d  = rd_q + PW'(pop);
        cnt_d = cnt_q + CW'(push_n) - CW'(pop);
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem_q[wr_q] <= crk_u0;
        if (push_n == 2'd2) mem_q[wr_p1] <= crk_u1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            undef_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            undef_q <= accept && crk_undef;
        end
    end

endmodule

// File: tb/tb_decode_uop_queue.sv
// Directed bench for decode_uop_queue: decode rules, cracking,
// backpressure, flush and asynchronous reset.
module tb_decode_uop_queue;
    import decode_uop_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic        instr_ready_o;
    logic        flush_i;
    logic        uop_valid_o;
    logic [63:0] uop_o;
    logic        uop_ready_i;
    logic [3:0]  count_o;
    logic        undef_o;

    int checks = 0;
    int errors = 0;
    uop_t h, e;

    decode_uop_queue #(
        .DEPTH     (8),
        .UOP_W     (64),
        .SPLIT_RSR (1'b1),
        .TMP_REG   (6'd16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .instr_ready_o (instr_ready_o),
        .flush_i       (flush_i),
        .uop_valid_o   (uop_valid_o),
        .uop_o         (uop_o),
        .uop_ready_i   (uop_ready_i),
        .count_o       (count_o),
        .undef_o       (undef_o)
    );

    always #5 clk = ~clk;

    function automatic uop_t mk(uop_class_e c, uop_type_e t,
                                logic [11:0] imm, logic [5:0] s0,
                                logic [5:0] s1, logic [5:0] s2,
                                logic [5:0] d0, logic dv,
                                logic [3:0] cnd);
        uop_t u;
        u = '0;
        u.valid = 1'b1;
        u.cond = cnd;
        u.cls = c;
        u.typ = t;
        u.imm12 = imm;
        u.src0 = s0;
        u.src1 = s1;
        u.src2 = s2;
        u.dst0 = d0;
        u.dst0_vld = dv;
        return u;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        instr_valid_i = 1'b1;
        instr_i = w;
        tick();
        instr_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        instr_valid_i = 1'b0;
        instr_i = '0;
        flush_i = 1'b0;
        uop_ready_i = 1'b0;
        #12;
        checks++;
        if ({instr_ready_o, uop_valid_o, undef_o, count_o} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000000",
                     {instr_ready_o, uop_valid_o, undef_o, count_o});
        end
        checks++;
        if (uop_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_uop got %h want 0", uop_o);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (instr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", instr_ready_o);
        end
    endtask

    task automatic test_add_cmp();
        push(32'hE2821005);
        h = uop_o;
        e = mk(CLS_INTEGER, TY_IMM, 12'h005, 6'd2, 6'd0, 6'd0,
               6'd1, 1'b1, 4'hE);
        checks++;
        if (uop_valid_o !== 1'b1 || count_o !== 4'd1 || h !== e) begin
            errors++;
            $display("FAIL add_imm got v=%b c=%0d %h want v=1 c=1 %h",
                     uop_valid_o, count_o, h, e);
        end
        push(32'hE3530000);
        uop_ready_i = 1'b1;
        tick();
        h = uop_o;
        e = mk(CLS_INTEGER, TY_IMM, 12'h000, 6'd3, 6'd0, 6'd0,
               6'd0, 1'b0, 4'hE);
        checks++;
        if (count_o !== 4'd1 || h !== e) begin
            errors++;
            $display("FAIL cmp_imm got c=%0d %h want c=1 %h",
                     count_o, h, e);
        end
        tick();
        uop_ready_i = 1'b0;
    endtask

    task automatic test_rsr();
        push(32'hE0810312);
        h = uop_o;
        e = mk(CLS_INTEGER, TY_SHIFT_LSL, 12'h000, 6'd2, 6'd3, 6'd0,
               6'd16, 1'b1, 4'hE);
        checks++;
        if (count_o !== 4'd2 || h !== e) begin
            errors++;
            $display("FAIL rsr_uop0 got c=%0d %h want c=2 %h",
                     count_o, h, e);
        end
        uop_ready_i = 1'b1;
        tick();
        h = uop_o;
        e = mk(CLS_INTEGER, TY_REG, 12'h000, 6'd1, 6'd16, 6'd0,
               6'd0, 1'b1, 4'hE);
        checks++;
        if (count_o !== 4'd1 || h !== e) begin
            errors++;
            $display("FAIL rsr_uop1 got c=%0d %h want c=1 %h",
                     count_o, h, e);
        end
        tick();
        uop_ready_i = 1'b0;
        push(32'h10810312);
        h = uop_o;
        e = mk(CLS_INTEGER, TY_SHIFT_LSL, 12'h000, 6'd1, 6'd2, 6'd3,
               6'd0, 1'b1, 4'h1);
        checks++;
        if (count_o !== 4'd1 || h !== e) begin
            errors++;
            $display("FAIL rsr_ne got c=%0d %h want c=1 %h",
                     count_o, h, e);
        end
        uop_ready_i = 1'b1;
        tick();
        uop_ready_i = 1'b0;
    endtask

    task automatic test_dp_reg_mul();
        uop_ready_i = 1'b1;
        push(32'hE0810002);
        h = uop_o;
        e = mk(CLS_INTEGER, TY_REG, 12'h000, 6'd1, 6'd2, 6'd0,
               6'd0, 1'b1, 4'hE);
        checks++;
        if (h !== e) begin
            errors++;
            $display("FAIL dp_reg got %h want %h", h, e);
        end
        push(32'hE0810222);
        h = uop_o;
        e = mk(CLS_INTEGER_M, TY_SHIFT_LSR, 12'h222, 6'd1, 6'd2, 6'd0,
               6'd0, 1'b1, 4'hE);
        checks++;
        if (h !== e) begin
            errors++;
            $display("FAIL dp_shift got %h want %h", h, e);
        end
        push(32'hE0050796);
        h = uop_o;
        checks++;
        if ({h.cls, h.typ, h.src0, h.src1, h.dst0, h.dst0_vld}
            !== {CLS_INTEGER_M, TY_MUL, 6'd6, 6'd7, 6'd5, 1'b1}) begin
            errors++;
            $display("FAIL mul got %h", h);
        end
        tick();
        uop_ready_i = 1'b0;
    endtask

    task automatic test_load_store();
        uop_ready_i = 1'b1;
        push(32'hE5910004);
        h = uop_o;
        checks++;
        if ({h.cls, h.src0, h.dst0, h.dst0_vld, h.imm12}
            !== {CLS_LOAD, 6'd1, 6'd0, 1'b1, 12'h004}) begin
            errors++;
            $display("FAIL ldr got %h", h);
        end
        push(32'hE5843008);
        h = uop_o;
        checks++;
        if ({h.cls, h.src0, h.src1, h.dst0_vld, h.imm12}
            !== {CLS_STORE, 6'd4, 6'd3, 1'b0, 12'h008}) begin
            errors++;
            $display("FAIL str got %h", h);
        end
        tick();
        uop_ready_i = 1'b0;
    endtask

    task automatic test_nop_undef();
        instr_valid_i = 1'b1;
        instr_i = 32'hE320F000;
        #1;
        checks++;
        if (instr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL nop_ready got %b want 1", instr_ready_o);
        end
        tick();
        checks++;
        if (count_o !== 4'd0 || undef_o !== 1'b0) begin
            errors++;
            $display("FAIL nop got c=%0d u=%b want c=0 u=0",
                     count_o, undef_o);
        end
        instr_i = 32'hE7F000F0;
        tick();
        instr_valid_i = 1'b0;
        checks++;
        if (count_o !== 4'd0 || undef_o !== 1'b1) begin
            errors++;
            $display("FAIL udf got c=%0d u=%b want c=0 u=1",
                     count_o, undef_o);
        end
        tick();
        checks++;
        if (undef_o !== 1'b0) begin
            errors++;
            $display("FAIL udf_pulse got %b want 0", undef_o);
        end
    endtask

    task automatic test_full();
        int acc = 0;
        instr_valid_i = 1'b1;
        instr_i = 32'hE2821005;
        for (int i = 0; i < 10; i++) begin
            if (instr_ready_o) acc++;
            tick();
        end
        instr_valid_i = 1'b0;
        checks++;
        if (acc !== 7 || count_o !== 4'd7 || instr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full got acc=%0d c=%0d r=%b want 7 7 0",
                     acc, count_o, instr_ready_o);
        end
        uop_ready_i = 1'b1;
        tick();
        uop_ready_i = 1'b0;
        checks++;
        if (count_o !== 4'd6 || instr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_pop got c=%0d r=%b want 6 1",
                     count_o, instr_ready_o);
        end
        uop_ready_i = 1'b1;
        for (int i = 0; i < 20 && count_o != 4'd0; i++) tick();
        uop_ready_i = 1'b0;
        checks++;
        if (count_o !== 4'd0) begin
            errors++;
            $display("FAIL drain got c=%0d want 0", count_o);
        end
    endtask

    task automatic test_back_to_back();
        uop_ready_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            instr_valid_i = 1'b1;
            instr_i = 32'hE2821000 | 32'(i);
            tick();
            h = uop_o;
            checks++;
            if (count_o !== 4'd1 || h.imm12 !== 12'(i)) begin
                errors++;
                $display("FAIL b2b_%0d got c=%0d imm=%h want c=1 imm=%h",
                         i, count_o, h.imm12, 12'(i));
            end
        end
        instr_valid_i = 1'b0;
        tick();
        uop_ready_i = 1'b0;
        checks++;
        if (count_o !== 4'd0) begin
            errors++;
            $display("FAIL b2b_end got c=%0d want 0", count_o);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push(32'hE2821005);
        checks++;
        if (count_o !== 4'd5) begin
            errors++;
            $display("FAIL flush_fill got c=%0d want 5", count_o);
        end
        flush_i = 1'b1;
        uop_ready_i = 1'b1;
        instr_valid_i = 1'b1;
        #1;
        checks++;
        if (instr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b want 0", instr_ready_o);
        end
        tick();
        flush_i = 1'b0;
        instr_valid_i = 1'b0;
        uop_ready_i = 1'b0;
        checks++;
        if (count_o !== 4'd0 || uop_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush got c=%0d v=%b want 0 0",
                     count_o, uop_valid_o);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) push(32'hE5910004);
        checks++;
        if (count_o !== 4'd3) begin
            errors++;
            $display("FAIL pre_rst got c=%0d want 3", count_o);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (count_o !== 4'd0 || uop_valid_o !== 1'b0
            || instr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got c=%0d v=%b r=%b want 0 0 0",
                     count_o, uop_valid_o, instr_ready_o);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (count_o !== 4'd0 || instr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL post_rst got c=%0d r=%b want 0 1",
                     count_o, instr_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_add_cmp();
        test_rsr();
        test_dp_reg_mul();
        test_load_store();
        test_nop_undef();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_uop_queue.md
Name: decode_uop_queue

Overview:
Next-generation decode stage: decodes 32-bit ARM instructions into micro-ops in the shared uop format, then buffers them in a DEPTH-entry FIFO between fetch and rename/issue.
- Unconditional register-shifted-register (RSR) data-processing instructions are cracked into two uops.
- Both sides use a valid/ready handshake.
- A synchronous flush supports branch redirect.

Parameters:
DEPTH, 8, uop FIFO entries; power of two, >= 4
UOP_W, 64, uop width; must equal the package uop width
SPLIT_RSR, 1, 1 = crack unconditional RSR into two uops; 0 = single INTEGER_M uop
TMP_REG, 16, 6-bit physical temp register index used between cracked uops

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
instr_valid_i  input  1  fetch presents instruction
instr_i  input  32  instruction word
instr_ready_o  output  1  decode can accept this cycle
flush_i  input  1  synchronous flush of all buffered uops
uop_valid_o  output  1  head uop valid
uop_o  output  UOP_W  head uop
uop_ready_i  input  1  consumer takes head uop
count_o  output  $clog2(DEPTH+1)  occupied entries
undef_o  output  1  one-cycle pulse: accepted encoding not decodable

Behaviour:
- Reset (rst low, async): FIFO pointers = 0, count_o = 0, uop_valid_o = 0, uop_o = 0, undef_o = 0, instr_ready_o = 0 while rst is low.
- Accept = instr_valid_i & instr_ready_o.
- instr_ready_o = !flush_i & (DEPTH - count_o >= 2). The check uses registered count and ignores a same-cycle pop; this reserves worst-case crack space.
- Latency: accepted instruction's uop(s) are written at the next rising edge.
- uop_valid_o = (count_o != 0); uop_o is driven from head storage with no combinational path from instr_i.
- Pop = uop_valid_o & uop_ready_i; the head advances at the edge.
- Simultaneous push of n uops and a pop: count += n - 1.
- Pointers wrap modulo DEPTH.
- Decode rules. Every uop has VALID_B = 1 and COND = instr[31:28]; SRC/DST fields are 6 bits.
  - DP immediate (bits 27:25 = 001, excluding MSR/hint space): class INTEGER, type IMM, IMM_12 = instr[11:0], SRC_0 = Rn, DST_0 = Rd.
  - DP register, shift LSL #0: class INTEGER, type REG, SRC_0 = Rn, SRC_1 = Rm.
  - DP register, other immediate shift: class INTEGER_M, type SHIFT_LSL/LSR/ASR/ROR, SRC_0 = Rn, SRC_1 = Rm, IMM_12 = instr[11:0].
  - RSR, cond != AL, or SPLIT_RSR = 0: one uop, SRC_0 = Rn, SRC_1 = Rm, SRC_2 = Rs, type SHIFT_x. Class is INTEGER if cond != AL, else INTEGER_M.
  - RSR, cond = AL, SPLIT_RSR = 1, uop0: INTEGER, type SHIFT_x, SRC_0 = Rm, SRC_1 = Rs, DST_0 = TMP_REG, DST_0_VALID = 1.
  - RSR, cond = AL, SPLIT_RSR = 1, uop1: INTEGER, type REG, SRC_0 = Rn, SRC_1 = TMP_REG, DST_0 = Rd. Both uops are written in the same edge, uop0 first.
  - Multiply (bit 24 = 0, bits 7:4 = 1001): INTEGER_M, type MUL, SRC_0 = Rm, SRC_1 = Rs, SRC_2 = Rn (accumulate), DST_0 = instr[19:16].
  - Load/store (bits 27:25 = 01x): LOAD if bit 20, else STORE. SRC_0 = Rn, IMM_12 = instr[11:0]. LOAD: DST_0 = Rd. STORE: SRC_1 = Rd.
  - DST_0_VALID = 1 except for CMP, CMN, TST, TEQ and STORE.
  - NOP hint (0x?320F000): accepted, no uop written.
  - Any other encoding: accepted, no uop written; undef_o pulses at the next edge.
- flush_i high at an edge: pointers and count = 0. Any same-cycle accept is impossible because ready is low; any same-cycle pop is discarded.
- Flush has priority over push and pop.
- Reset mid-operation discards all contents immediately.

Decomposition:
- Shared package micro_operations.v holds:
  - uop field MSB/LSB defines, widened to 6-bit SRC/DST;
  - class codes INTEGER, INTEGER_M, LOAD, STORE;
  - type codes IMM, REG, SHIFT_x, MUL;
  - the UOP_W define.
- Shared package instructions.v holds COND_x, OP_x and SHIFT_x.
- Natural sub-module: uop_cracker. It is combinational: instr_i -> {n_uops[1:0], uop0, uop1, undef}. The parent holds the FIFO, counters and handshake.

Test Plan:
- ADD r1,r2,#5 (0xE2821005), consumer ready: one cycle later uop_valid_o = 1 with INTEGER/IMM, IMM_12 = 0x005, SRC_0 = 2, DST_0 = 1, DST_0_VALID = 1. CMP r3,#0 (0xE3530000) gives DST_0_VALID = 0.
- 0xE0810312 (ADD r0,r1,r2,LSL r3), SPLIT_RSR = 1: count_o goes 0 -> 2. First uop: SHIFT_LSL, SRC_0 = 2, SRC_1 = 3, DST_0 = 16. Second uop: REG, SRC_0 = 1, SRC_1 = 16, DST_0 = 0. 0x10810312 (NE) gives exactly one INTEGER uop with SRC_2 = 3.
- uop_ready_i = 0, stream ADDs: instr_ready_o drops once count_o = DEPTH-1. With DEPTH = 8 there are 7 accepts. One pop, and ready is 1 on the following cycle.
- 0xE320F000 (NOP): instr_ready_o = 1 and accepted, count_o unchanged. 0xE7F000F0 (UDF): undef_o pulses once, no uop.
- Fill 5 uops, assert flush_i with uop_ready_i = 1: next cycle count_o = 0, uop_valid_o = 0. instr_ready_o = 0 during flush.
- LDR r0,[r1,#4] (0xE5910004): LOAD, SRC_0 = 1, DST_0 = 0, IMM_12 = 4. Assert rst low mid-stream: uop_valid_o = 0 and count_o = 0 immediately, without waiting for a clock edge.
